ysyx_23060171_regfile: RTL and testbench

Architectural register file and CSR file sitting in the IDU, the receiving end of the writeback interface driven by the WBU. It accepts one writeback beat per cycle over a valid/ready handshake, applies GPR and CSR writes plus trap side effects, serves combinational reads to decode, and keeps a per-register pending-write scoreboard so decode can stall on RAW hazards.

---
 rtl/ysyx_23060171_regfile.sv | 219 +++++++++++++++++++++
 tb/tb_ysyx_23060171_regfile.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060171_regfile.sv
// ----------------------------------------------------------------------------
// ysyx_23060171_regfile
//   Architectural GPR + CSR file in the IDU. It takes writeback beats from the
//   WBU over a valid/ready handshake. Each beat applies GPR and CSR writes and
//   the trap side effects. Reads to decode are combinational. A per-GPR
//   pending-writer counter lets decode stall on RAW hazards.
//
// Optional feature:
//   YSYX_23060171_RF_BYPASS_EN - when defined, a firing beat is forwarded to
//   the same-cycle GPR/CSR read ports. busyN is also masked when that beat
//   retires the last pending writer of raddrN. When undefined, readers see
//   the new state one cycle after the write.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   wb_valid/wb_ready   writeback handshake (fire = valid & ready)
//   rwD/WDW/RegwriteED  GPR write index / data / enable
//   crwD/CWDW/CSRWriteED CSR write address / data / enable
//   trap_en/trap_cause  trap beat: update mcause and mstatus.MIE/MPIE
//   raddr1/2, rdata1/2  GPR read ports (x0 reads 0)
//   craddr, crdata      CSR read port
//   iss_valid/iss_rd    decode issues an instruction writing iss_rd
//   iss_ready           scoreboard can take the issue
//   busy1/busy2         raddr1/raddr2 has a pending writer
//   sb_err              sticky scoreboard underflow
// ----------------------------------------------------------------------------
module ysyx_23060171_regfile #(
  parameter int NR_GPR = 32,
  parameter int SB_W   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  rwD,
  input  logic [31:0] WDW,
  input  logic        RegwriteED,
  input  logic [11:0] crwD,
  input  logic [31:0] CWDW,
  input  logic        CSRWriteED,
  input  logic        trap_en,
  input  logic [31:0] trap_cause,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic [11:0] craddr,
  output logic [31:0] crdata,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  output logic        busy1,
  output logic        busy2,
  output logic        sb_err
);

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  localparam logic [31:0] MSTATUS_RST   = 32'h0000_1800;
  localparam logic [31:0] MVENDORID_VAL = 32'h7973_7978;
  localparam logic [31:0] MARCHID_VAL   = 32'h015F_DECB;

  localparam logic [SB_W-1:0] CNT_MAX = {SB_W{1'b1}};
  localparam logic [SB_W-1:0] CNT_ONE = SB_W'(1);

  logic            r_wb_ready;
  logic [31:0]     r_gpr [NR_GPR];
  logic [31:0]     r_mstatus;
  logic [31:0]     r_mtvec;
  logic [31:0]     r_mepc;
  logic [31:0]     r_mcause;
  logic [SB_W-1:0] r_cnt [NR_GPR];
  logic            r_sb_err;

  logic            w_fire;
  logic            w_gpr_we;
  logic            w_csr_we;
  logic            w_trap;
  logic            w_inc;
  logic            w_dec;
  logic [31:0]     w_mstatus_nxt;
  logic [31:0]     w_mtvec_nxt;
  logic [31:0]     w_mepc_nxt;
  logic [31:0]     w_mcause_nxt;
  logic [31:0]     w_gpr_rd1;
  logic [31:0]     w_gpr_rd2;
  logic            w_busy1_raw;
  logic            w_busy2_raw;

  function automatic logic [31:0] f_csr_rd(
    input logic [11:0] a,
    input logic [31:0] ms,
    input logic [31:0] mt,
    input logic [31:0] me,
    input logic [31:0] mc
  );
    logic [31:0] v;
    v = 32'h0;
    case (a)
      CSR_MSTATUS:   v = ms;
      CSR_MTVEC:     v = mt;
      CSR_MEPC:      v = me;
      CSR_MCAUSE:    v = mc;
      CSR_MVENDORID: v = MVENDORID_VAL;
      CSR_MARCHID:   v = MARCHID_VAL;
      default:       v = 32'h0;
    endcase
    return v;
  endfunction

  assign wb_ready = r_wb_ready;
  assign sb_err   = r_sb_err;

  assign w_fire   = wb_valid & r_wb_ready;
  assign w_gpr_we = w_fire & RegwriteED & (rwD != 5'd0);
  assign w_csr_we = w_fire & CSRWriteED;
  assign w_trap   = w_fire & trap_en;
  assign w_dec    = w_gpr_we;

  // A full counter can still accept an issue if the same register retires a
  // writer this cycle, because the net count is then unchanged.
  assign iss_ready = r_wb_ready &
                     ((iss_rd == 5'd0) ||
                      (r_cnt[iss_rd] != CNT_MAX) ||
                      (w_dec && (rwD == iss_rd)));
  assign w_inc = iss_valid & iss_ready & (iss_rd != 5'd0);

  // The trap update is applied after the CSR write so it wins on mcause and
  // on the MIE/MPIE bits. MPIE takes MIE from the pre-beat state.
  always_comb begin
    w_mstatus_nxt = r_mstatus;
    w_mtvec_nxt   = r_mtvec;
    w_mepc_nxt    = r_mepc;
    w_mcause_nxt  = r_mcause;
    if (w_csr_we) begin
      case (crwD)
        CSR_MSTATUS: w_mstatus_nxt = CWDW;
        CSR_MTVEC:   w_mtvec_nxt   = CWDW;
        CSR_MEPC:    w_mepc_nxt    = CWDW;
        CSR_MCAUSE:  w_mcause_nxt  = CWDW;
        default:     ;
      endcase
    end
    if (w_trap) begin
      w_mcause_nxt     = trap_cause;
      w_mstatus_nxt[7] = r_mstatus[3];
      w_mstatus_nxt[3] = 1'b0;
    end
  end

  assign w_gpr_rd1   = (raddr1 == 5'd0) ? 32'h0 : r_gpr[raddr1];
  assign w_gpr_rd2   = (raddr2 == 5'd0) ? 32'h0 : r_gpr[raddr2];
  assign w_busy1_raw = (raddr1 != 5'd0) && (r_cnt[raddr1] != '0);
  assign w_busy2_raw = (raddr2 != 5'd0) && (r_cnt[raddr2] != '0);

`ifdef YSYX_23060171_RF_BYPASS_EN
  assign rdata1 = (w_gpr_we && (rwD == raddr1)) ? WDW : w_gpr_rd1;
  assign rdata2 = (w_gpr_we && (rwD == raddr2)) ? WDW : w_gpr_rd2;
  assign crdata = f_csr_rd(craddr, w_mstatus_nxt, w_mtvec_nxt, w_mepc_nxt, w_mcause_nxt);
  // Mask only when this beat retires the last writer and no new writer to
  // the same register is issued in the same cycle.
  assign busy1 = w_busy1_raw &
                 ~(w_dec && (rwD == raddr1) && (r_cnt[raddr1] == CNT_ONE) &&
                   !(w_inc && (iss_rd == raddr1)));
  assign busy2 = w_busy2_raw &
                 ~(w_dec && (rwD == raddr2) && (r_cnt[raddr2] == CNT_ONE) &&
                   !(w_inc && (iss_rd == raddr2)));
`else
  assign rdata1 = w_gpr_rd1;
  assign rdata2 = w_gpr_rd2;
  assign crdata = f_csr_rd(craddr, r_mstatus, r_mtvec, r_mepc, r_mcause);
  assign busy1  = w_busy1_raw;
  assign busy2  = w_busy2_raw;
`endif

  // wb_ready comes up on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_ready <= 1'b0;
      r_mstatus  <= MSTATUS_RST;
      r_mtvec    <= 32'h0;
      r_mepc     <= 32'h0;
      r_mcause   <= 32'h0;
      r_sb_err   <= 1'b0;
      for (int r = 0; r < NR_GPR; r++) begin
        r_gpr[r] <= 32'h0;
        r_cnt[r] <= '0;
      end
    end else begin
      r_wb_ready <= 1'b1;
      r_mstatus  <= w_mstatus_nxt;
      r_mtvec    <= w_mtvec_nxt;
      r_mepc     <= w_mepc_nxt;
      r_mcause   <= w_mcause_nxt;
      if (w_gpr_we) begin
        r_gpr[rwD] <= WDW;
      end
      if (w_dec && (r_cnt[rwD] == '0) && !(w_inc && (iss_rd == rwD))) begin
        r_sb_err <= 1'b1;
      end
      // An increment is never taken on a full counter (iss_ready), and a
      // decrement at zero saturates.
      for (int r = 1; r < NR_GPR; r++) begin
        if ((w_inc && (iss_rd == 5'(r))) && !(w_dec && (rwD == 5'(r)))) begin
          r_cnt[r] <= r_cnt[r] + CNT_ONE;
        end else if (!(w_inc && (iss_rd == 5'(r))) && (w_dec && (rwD == 5'(r))) &&
                     (r_cnt[r] != '0)) begin
          r_cnt[r] <= r_cnt[r] - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060171_regfile.sv
module tb_ysyx_23060171_regfile;

  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  rwD;
  logic [31:0] WDW;
  logic        RegwriteED;
  logic [11:0] crwD;
  logic [31:0] CWDW;
  logic        CSRWriteED;
  logic        trap_en;
  logic [31:0] trap_cause;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic [11:0] craddr;
  logic [31:0] crdata;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        busy1, busy2;
  logic        sb_err;

  ysyx_23060171_regfile #(.NR_GPR(32), .SB_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .rwD(rwD), .WDW(WDW), .RegwriteED(RegwriteED),
    .crwD(crwD), .CWDW(CWDW), .CSRWriteED(CSRWriteED),
    .trap_en(trap_en), .trap_cause(trap_cause),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .craddr(craddr), .crdata(crdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .busy1(busy1), .busy2(busy2), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1, rd2, crd;
    logic        b1, b2, ir, wr, err;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state
  logic [31:0] m_gpr [32];
  logic [31:0] m_ms, m_mt, m_me, m_mc;
  int          m_cnt [32];
  bit          m_err, m_rdy;

  function automatic logic [31:0] csr_val(input logic [11:0] a, input logic [31:0] ms,
                                          input logic [31:0] mt, input logic [31:0] me,
                                          input logic [31:0] mc);
    if (a == 12'h300) return ms;
    if (a == 12'h305) return mt;
    if (a == 12'h341) return me;
    if (a == 12'h342) return mc;
    if (a == 12'hF11) return 32'h7973_7978;
    if (a == 12'hF12) return 32'h015F_DECB;
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_gpr[i] = 32'h0;
      m_cnt[i] = 0;
    end
    m_ms = 32'h0000_1800; m_mt = 0; m_me = 0; m_mc = 0;
    m_err = 0; m_rdy = 0;
  endtask

  // Called at posedge+1 with inputs already applied: computes the expected
  // outputs for this cycle, waits for the edge, then commits the model.
  task automatic step();
    exp_t e;
    logic [31:0] n_gpr [32];
    int          n_cnt [32];
    logic [31:0] n_ms, n_mt, n_me, n_mc;
    bit n_err, fire, gw, inc;
    if (!rst_n) model_reset();
    e.wr = m_rdy && rst_n;
    fire = wb_valid && e.wr;
    gw   = fire && RegwriteED && (rwD != 0);
    e.ir = e.wr && ((iss_rd == 0) || (m_cnt[iss_rd] < MAXC) || (gw && rwD == iss_rd));
    inc  = iss_valid && e.ir && (iss_rd != 0);

    n_gpr = m_gpr; n_cnt = m_cnt; n_err = m_err;
    n_ms = m_ms; n_mt = m_mt; n_me = m_me; n_mc = m_mc;
    if (gw) n_gpr[rwD] = WDW;
    if (fire && CSRWriteED) begin
      if (crwD == 12'h300) n_ms = CWDW;
      if (crwD == 12'h305) n_mt = CWDW;
      if (crwD == 12'h341) n_me = CWDW;
      if (crwD == 12'h342) n_mc = CWDW;
    end
    if (fire && trap_en) begin
      n_mc    = trap_cause;
      n_ms[7] = m_ms[3];
      n_ms[3] = 1'b0;
    end
    if (inc) n_cnt[iss_rd] = n_cnt[iss_rd] + 1;
    if (gw) begin
      if (n_cnt[rwD] > 0) n_cnt[rwD] = n_cnt[rwD] - 1;
      else n_err = 1;
    end

`ifdef YSYX_23060171_RF_BYPASS_EN
    e.rd1 = (raddr1 == 0) ? 32'h0 : n_gpr[raddr1];
    e.rd2 = (raddr2 == 0) ? 32'h0 : n_gpr[raddr2];
    e.crd = csr_val(craddr, n_ms, n_mt, n_me, n_mc);
    e.b1  = (raddr1 != 0) && (m_cnt[raddr1] != 0) && !(gw && rwD == raddr1 && n_cnt[raddr1] == 0);
    e.b2  = (raddr2 != 0) && (m_cnt[raddr2] != 0) && !(gw && rwD == raddr2 && n_cnt[raddr2] == 0);
`else
    e.rd1 = (raddr1 == 0) ? 32'h0 : m_gpr[raddr1];
    e.rd2 = (raddr2 == 0) ? 32'h0 : m_gpr[raddr2];
    e.crd = csr_val(craddr, m_ms, m_mt, m_me, m_mc);
    e.b1  = (raddr1 != 0) && (m_cnt[raddr1] != 0);
    e.b2  = (raddr2 != 0) && (m_cnt[raddr2] != 0);
`endif
    e.err = m_err;
    q.push_back(e);

    @(posedge clk);
    if (rst_n) begin
      m_gpr = n_gpr; m_cnt = n_cnt; m_err = n_err;
      m_ms = n_ms; m_mt = n_mt; m_me = n_me; m_mc = n_mc;
      m_rdy = 1;
    end else begin
      model_reset();
    end
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wb_ready",  {31'h0, wb_ready},  {31'h0, e.wr});
        chk("iss_ready", {31'h0, iss_ready}, {31'h0, e.ir});
        chk("rdata1",    rdata1, e.rd1);
        chk("rdata2",    rdata2, e.rd2);
        chk("crdata",    crdata, e.crd);
        chk("busy1",     {31'h0, busy1},  {31'h0, e.b1});
        chk("busy2",     {31'h0, busy2},  {31'h0, e.b2});
        chk("sb_err",    {31'h0, sb_err}, {31'h0, e.err});
      end
    end
  end

  task automatic idle();
    wb_valid = 0; RegwriteED = 0; CSRWriteED = 0; trap_en = 0; iss_valid = 0;
  endtask

  task automatic beat(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1; RegwriteED = 1; rwD = r; WDW = d; CSRWriteED = 0; trap_en = 0;
  endtask

  initial begin
    rst_n = 0; idle();
    rwD = 0; WDW = 0; crwD = 0; CWDW = 0; trap_cause = 0;
    raddr1 = 5; raddr2 = 0; craddr = 12'h300; iss_rd = 0;
    model_reset();
    @(posedge clk); #1;

    // Reset and release
    step(); step();
    rst_n = 1; step();
    craddr = 12'hF12; step();
    craddr = 12'hF11; step();

    // GPR writes, x0 drop
    beat(5, 32'hDEAD_BEEF); step();
    beat(0, 32'h0000_1234); raddr1 = 5; raddr2 = 0; step();
    idle(); step();

    // Scoreboard: fill, stall, drain, underflow
    raddr1 = 7; raddr2 = 7;
    iss_valid = 1; iss_rd = 7;
    repeat (4) step();
    iss_valid = 0;
    for (int i = 0; i < 3; i++) begin
      beat(7, 32'h100 + i); step();
    end
    idle(); step();
    beat(7, 32'h0BAD); step();
    idle(); step();

    // Trap beat together with an mepc write
    wb_valid = 1; CSRWriteED = 1; crwD = 12'h300; CWDW = 32'h0000_1808; craddr = 12'h300; step();
    trap_en = 1; trap_cause = 32'h8000_0007; crwD = 12'h341; CWDW = 32'h8000_0100; step();
    idle();
    craddr = 12'h342; step();
    craddr = 12'h341; step();
    craddr = 12'h300; step();
    // Trap wins over a direct mcause write in the same beat
    wb_valid = 1; CSRWriteED = 1; trap_en = 1; crwD = 12'h342; CWDW = 32'h1111_1111;
    trap_cause = 32'h0000_000B; craddr = 12'h342; step();
    idle(); step();

    // Same-cycle read of a written register
    raddr1 = 3; beat(3, 32'h55); step();
    idle(); step();

    // Reset between two back-to-back beats
    raddr1 = 9; raddr2 = 10;
    beat(9, 32'h0000_AAAA); step();
    beat(10, 32'h0000_BBBB); rst_n = 0; step();
    idle(); rst_n = 1; step();
    step();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      logic [11:0] addrs [8];
      addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341; addrs[3] = 12'h342;
      addrs[4] = 12'hF11; addrs[5] = 12'hF12; addrs[6] = 12'h123; addrs[7] = 12'h7C0;
      rst_n      = ($urandom_range(0, 99) != 0);
      wb_valid   = $urandom_range(0, 1) == 1;
      RegwriteED = $urandom_range(0, 2) != 0;
      rwD        = 5'($urandom_range(0, 7));
      WDW        = $urandom;
      CSRWriteED = $urandom_range(0, 3) == 0;
      crwD       = addrs[$urandom_range(0, 7)];
      CWDW       = $urandom;
      trap_en    = $urandom_range(0, 9) == 0;
      trap_cause = $urandom;
      iss_valid  = $urandom_range(0, 2) == 0;
      iss_rd     = 5'($urandom_range(0, 7));
      raddr1     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      raddr2     = 5'($urandom_range(0, 7));
      craddr     = addrs[$urandom_range(0, 7)];
      step();
    end
    rst_n = 1; idle(); step();

    // Drain the scoreboard queue with a bounded wait
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
